data_matrix_fetch_drive: RTL and testbench
==========================================

Name: data_matrix_fetch_drive

Overview:
- Instruction-fetch sequencer for the LC-3 data matrix; it is the bus-side producer feeding the IR load register.
- On a fetch request it latches PC into MAR and performs a memory read with a ready handshake.
- It captures the word into MDR, then drives MDR onto the 16-bit datapath bus while pulsing ld_ir for exactly one cycle, so the IR captures the instruction.
- It signals pc_inc to the PC logic and reports completion or memory timeout to the control FSM.

Parameters:
MEM_TIMEOUT, 255, max WAIT cycles without mem_r before abort; 0 disables the timeout.
TO_W, 8, width of the timeout counter; must satisfy MEM_TIMEOUT < 2**TO_W.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  reset, asynchronous, active-high.
fetch_start  input  1  fetch request from control FSM; sampled only in IDLE.
pc  input  16  current program counter.
mem_rdata  input  16  memory read data, valid when mem_r=1.
mem_r  input  1  memory ready; read data valid this cycle.
mem_en  output  1  memory read enable.
mem_addr  output  16  memory address (MAR contents).
bus  output  16  datapath bus contribution; MDR when gate_mdr=1, else 16'h0000 (OR-bus, no tristate).
gate_mdr  output  1  high while this block owns the bus.
ld_ir  output  1  IR load strobe, one cycle.
pc_inc  output  1  one-cycle PC increment pulse.
fetch_done  output  1  one-cycle pulse, coincident with ld_ir.
fetch_err  output  1  sticky timeout flag.
busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, rst=1): state=IDLE; mar=0, mdr=0, timeout counter=0. All outputs go 0 immediately: mem_en, mem_addr, bus, gate_mdr, ld_ir, pc_inc, fetch_done, fetch_err, busy.
- States: IDLE, WAIT, DRIVE. All outputs except bus/mem_addr are registered or decoded from state only; there is no combinational path from inputs to outputs.
- IDLE + fetch_start=1 at edge N:
  - mar<=pc; fetch_err<=0; counter<=0; state->WAIT.
  - pc_inc=1 for exactly cycle N+1.
- WAIT:
  - mem_en=1; mem_addr=mar.
  - If mem_r=1 at an edge: mdr<=mem_rdata; state->DRIVE.
  - Otherwise the counter increments. If MEM_TIMEOUT!=0 and the counter reaches MEM_TIMEOUT with no mem_r: fetch_err<=1, state->IDLE, no ld_ir, no fetch_done.
  - mem_r arriving on the same edge the counter hits the limit takes priority: the fetch completes and no error is raised.
- DRIVE (exactly one cycle):
  - gate_mdr=1, bus=mdr, ld_ir=1, fetch_done=1; mem_en=0.
  - state->IDLE at the next edge.
- Minimum latency: fetch_start sampled at edge N, mem_r=1 in cycle N+1, ld_ir/fetch_done/bus valid in cycle N+2. Each extra wait state adds one cycle.
- Ignored inputs:
  - fetch_start while busy (WAIT/DRIVE) is ignored and not queued.
  - mem_r outside WAIT is ignored.
  - pc is sampled only on the accepting edge; later changes do not affect mem_addr.
- Back-to-back: fetch_start high in the DRIVE cycle is ignored; fetch_start in the following IDLE cycle is accepted, giving a 3-cycle minimum period.
- bus is exactly 16'h0000 whenever gate_mdr=0.
- fetch_err holds until the next accepted fetch_start or reset.
- busy = (state!=IDLE).

Test Plan:
- Zero-wait fetch: pc=16'h3000, fetch_start 1 cycle, mem_r=1 with mem_rdata=16'h1234 in first WAIT cycle -> mem_addr=16'h3000, mem_en=1 for 1 cycle, pc_inc in cycle N+1, ld_ir/fetch_done/gate_mdr with bus=16'h1234 in cycle N+2, bus=0 after.
- Wait states: mem_r delayed 3 cycles, mem_rdata=16'hABCD -> mem_en high 4 cycles, ld_ir exactly once in cycle N+5 with bus=16'hABCD, pc_inc exactly once.
- Timeout: MEM_TIMEOUT=4, mem_r never asserted -> mem_en high 4 cycles, fetch_err=1, no ld_ir, busy falls. Next fetch_start clears fetch_err and completes normally.
- Ignored start/pc change: fetch_start held high and pc changed to 16'h4000 during WAIT -> mem_addr stays 16'h3000, only one ld_ir. Continued fetch_start then starts a second fetch from IDLE 3 cycles after the first acceptance.
- Reset mid-operation: assert rst asynchronously in WAIT -> mem_en, busy, and bus go 0 without a clock edge. After release no ld_ir occurs, and a late mem_r is ignored.
- Limit collision: MEM_TIMEOUT=2, mem_r on the second WAIT edge -> ld_ir issued, fetch_err stays 0.

Source files
------------

// File: rtl/data_matrix_fetch_drive.sv
// LC-3 instruction-fetch sequencer: latches PC into MAR, reads memory with a
// ready handshake, then drives MDR onto the OR-bus while strobing ld_ir once.
module data_matrix_fetch_drive #(
  parameter int MEM_TIMEOUT = 255,
  parameter int TO_W        = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fetch_start,
  input  logic [15:0] pc,
  input  logic [15:0] mem_rdata,
  input  logic        mem_r,
  output logic        mem_en,
  output logic [15:0] mem_addr,
  output logic [15:0] bus,
  output logic        gate_mdr,
  output logic        ld_ir,
  output logic        pc_inc,
  output logic        fetch_done,
  output logic        fetch_err,
  output logic        busy,
  output logic [1:0]  o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_DRIVE = 2'd2
  } state_t;

  localparam bit            LP_TO_EN = (MEM_TIMEOUT != 0);
  localparam logic [TO_W-1:0] LP_LAST = TO_W'(MEM_TIMEOUT - 1);

  state_t          r_state;
  logic [15:0]     r_mar;
  logic [15:0]     r_mdr;
  logic [TO_W-1:0] r_cnt;
  logic            r_pc_inc;
  logic            r_err;
  logic            w_drive;

  // Memory handshake: mem_en is held for every WAIT cycle; a read completes on
  // the first rising edge where mem_en=1 and mem_r=1, and mem_rdata is taken
  // on that edge. mem_r is don't-care whenever mem_en=0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_mar    <= 16'h0000;
      r_mdr    <= 16'h0000;
      r_cnt    <= '0;
      r_pc_inc <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_pc_inc <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (fetch_start) begin
            r_mar    <= pc;
            r_err    <= 1'b0;
            r_cnt    <= '0;
            r_pc_inc <= 1'b1;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (mem_r) begin
            r_mdr   <= mem_rdata;
            r_state <= S_DRIVE;
          end else if (LP_TO_EN && (r_cnt == LP_LAST)) begin
            // Ready on the limit edge wins over the abort via the branch order.
            r_err   <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DRIVE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_drive     = (r_state == S_DRIVE);
  assign mem_en      = (r_state == S_WAIT);
  assign mem_addr    = r_mar;
  assign gate_mdr    = w_drive;
  assign ld_ir       = w_drive;
  assign fetch_done  = w_drive;
  assign bus         = w_drive ? r_mdr : 16'h0000;
  assign pc_inc      = r_pc_inc;
  assign fetch_err   = r_err;
  assign busy        = (r_state != S_IDLE);
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_data_matrix_fetch_drive.sv
// Directed bench for data_matrix_fetch_drive: one instance with a 4-cycle
// timeout and one with a 2-cycle timeout for the limit-collision case.
module tb_data_matrix_fetch_drive;

  logic        clk;
  logic        rst;
  logic        fetch_start;
  logic [15:0] pc;
  logic [15:0] mem_rdata;
  logic        mem_r;

  logic        mem_en, gate_mdr, ld_ir, pc_inc, fetch_done, fetch_err, busy;
  logic [15:0] mem_addr, bus;
  logic [1:0]  dbg_state;

  logic        mem_en2, gate_mdr2, ld_ir2, pc_inc2, fetch_done2, fetch_err2, busy2;
  logic [15:0] mem_addr2, bus2;
  logic [1:0]  dbg_state2;

  int checks;
  int failures;

  data_matrix_fetch_drive #(.MEM_TIMEOUT(4), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc(pc),
    .mem_rdata(mem_rdata), .mem_r(mem_r), .mem_en(mem_en), .mem_addr(mem_addr),
    .bus(bus), .gate_mdr(gate_mdr), .ld_ir(ld_ir), .pc_inc(pc_inc),
    .fetch_done(fetch_done), .fetch_err(fetch_err), .busy(busy),
    .o_dbg_state(dbg_state)
  );

  data_matrix_fetch_drive #(.MEM_TIMEOUT(2), .TO_W(8)) dut2 (
    .clk(clk), .rst(rst), .fetch_start(fetch_start), .pc(pc),
    .mem_rdata(mem_rdata), .mem_r(mem_r), .mem_en(mem_en2), .mem_addr(mem_addr2),
    .bus(bus2), .gate_mdr(gate_mdr2), .ld_ir(ld_ir2), .pc_inc(pc_inc2),
    .fetch_done(fetch_done2), .fetch_err(fetch_err2), .busy(busy2),
    .o_dbg_state(dbg_state2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int n_en, n_ld, n_inc, ld_cyc;
  logic [15:0] bus_at_ld;

  initial begin
    checks = 0; failures = 0;
    rst = 1'b1; fetch_start = 1'b0; pc = 16'h0000; mem_rdata = 16'h0000; mem_r = 1'b0;
    #12;
    check("rst_mem_en", {15'd0, mem_en}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd0);
    check("rst_bus", bus, 16'h0000);
    check("rst_addr", mem_addr, 16'h0000);
    check("rst_err", {15'd0, fetch_err}, 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // zero-wait fetch
    pc = 16'h3000; fetch_start = 1'b1;
    tick();
    check("zw_mem_en", {15'd0, mem_en}, 16'd1);
    check("zw_addr", mem_addr, 16'h3000);
    check("zw_pc_inc", {15'd0, pc_inc}, 16'd1);
    check("zw_ld_early", {15'd0, ld_ir}, 16'd0);
    fetch_start = 1'b0; mem_r = 1'b1; mem_rdata = 16'h1234;
    tick();
    mem_r = 1'b0;
    check("zw_ld_ir", {15'd0, ld_ir}, 16'd1);
    check("zw_done", {15'd0, fetch_done}, 16'd1);
    check("zw_gate", {15'd0, gate_mdr}, 16'd1);
    check("zw_bus", bus, 16'h1234);
    check("zw_mem_en_off", {15'd0, mem_en}, 16'd0);
    check("zw_pc_inc_off", {15'd0, pc_inc}, 16'd0);
    tick();
    check("zw_bus_after", bus, 16'h0000);
    check("zw_busy_after", {15'd0, busy}, 16'd0);

    // three wait states before ready
    pc = 16'h3002; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; mem_rdata = 16'hABCD;
    n_en = 0; n_ld = 0; n_inc = 0; ld_cyc = 0; bus_at_ld = 16'h0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_en) n_en++;
      if (pc_inc) n_inc++;
      if (ld_ir) begin n_ld++; ld_cyc = c; bus_at_ld = bus; end
      mem_r = (c == 4);
      tick();
    end
    mem_r = 1'b0;
    check("ws_mem_en_cycles", 16'(n_en), 16'd4);
    check("ws_ld_count", 16'(n_ld), 16'd1);
    check("ws_ld_cycle", 16'(ld_cyc), 16'd5);
    check("ws_bus", bus_at_ld, 16'hABCD);
    check("ws_pc_inc_count", 16'(n_inc), 16'd1);

    // timeout with mem_r never asserted
    pc = 16'h3004; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    n_en = 0; n_ld = 0;
    for (int c = 1; c <= 8; c++) begin
      if (mem_en) n_en++;
      if (ld_ir || fetch_done) n_ld++;
      tick();
    end
    check("to_mem_en_cycles", 16'(n_en), 16'd4);
    check("to_no_ld", 16'(n_ld), 16'd0);
    check("to_err", {15'd0, fetch_err}, 16'd1);
    check("to_busy", {15'd0, busy}, 16'd0);
    fetch_start = 1'b1;
    tick();
    check("to_err_clear", {15'd0, fetch_err}, 16'd0);
    fetch_start = 1'b0; mem_r = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    mem_r = 1'b0;
    check("to_retry_ld", {15'd0, ld_ir}, 16'd1);
    check("to_retry_bus", bus, 16'h5A5A);
    tick();

    // held fetch_start with pc change during WAIT
    pc = 16'h3000; fetch_start = 1'b1;
    tick();
    n_ld = 0;
    for (int c = 1; c <= 5; c++) begin
      if (c == 1) begin
        check("hs_addr_wait", mem_addr, 16'h3000);
        pc = 16'h4000;
      end
      if (ld_ir) n_ld++;
      if (c == 2) check("hs_addr_drive", mem_addr, 16'h3000);
      if (c == 3) check("hs_idle", {15'd0, busy}, 16'd0);
      if (c == 4) begin
        check("hs_second_accept", {15'd0, pc_inc}, 16'd1);
        check("hs_second_addr", mem_addr, 16'h4000);
        fetch_start = 1'b0;
      end
      mem_r = (c == 1) || (c == 4);
      mem_rdata = 16'h0F00 + 16'(c);
      tick();
    end
    mem_r = 1'b0;
    check("hs_ld_total", 16'(n_ld), 16'd2);
    tick();

    // asynchronous reset while in WAIT
    pc = 16'h3010; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0;
    check("ar_in_wait", {15'd0, mem_en}, 16'd1);
    #2 rst = 1'b1;
    #1;
    check("ar_mem_en", {15'd0, mem_en}, 16'd0);
    check("ar_busy", {15'd0, busy}, 16'd0);
    check("ar_bus", bus, 16'h0000);
    check("ar_addr", mem_addr, 16'h0000);
    @(negedge clk);
    rst = 1'b0; mem_r = 1'b1; mem_rdata = 16'hDEAD;
    n_ld = 0; n_en = 0;
    for (int c = 0; c < 3; c++) begin
      tick();
      if (ld_ir) n_ld++;
      if (busy) n_en++;
    end
    mem_r = 1'b0;
    check("ar_no_ld", 16'(n_ld), 16'd0);
    check("ar_stay_idle", 16'(n_en), 16'd0);

    // ready arriving on the timeout-limit edge (MEM_TIMEOUT=2 instance)
    pc = 16'h3020; fetch_start = 1'b1;
    tick();
    fetch_start = 1'b0; mem_r = 1'b0; mem_rdata = 16'hC0DE;
    tick();
    check("lc_still_wait", {15'd0, mem_en2}, 16'd1);
    mem_r = 1'b1;
    tick();
    mem_r = 1'b0;
    check("lc_ld_ir", {15'd0, ld_ir2}, 16'd1);
    check("lc_bus", bus2, 16'hC0DE);
    check("lc_err", {15'd0, fetch_err2}, 16'd0);
    tick();
    check("lc_err_after", {15'd0, fetch_err2}, 16'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
